// File: rtl/operand_loader_if.sv
// Byte-stream and operand-pair handshake bundle for operand_loader.
// Optional parity signals exist only when LOADER_PARITY_EN is defined.
interface operand_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        op_valid;
    logic        op_ready;
`ifdef LOADER_PARITY_EN
    logic        in_parity;
    logic        par_err;
`endif

    modport master (
        output in_data, in_valid, op_ready,
`ifdef LOADER_PARITY_EN
        output in_parity,
        input  par_err,
`endif
        input  in_ready, A, B, op_valid
    );

    modport slave (
        input  in_data, in_valid, op_ready,
`ifdef LOADER_PARITY_EN
        input  in_parity,
        output par_err,
`endif
        output in_ready, A, B, op_valid
    );
endinterface

// File: rtl/operand_loader.sv
// Assembles two 32-bit operands from a byte stream and holds the pair for a downstream adder.
// Define LOADER_PARITY_EN to add per-byte odd-parity checking (in_parity / par_err).
//
// state  | meaning
// LOAD_A | collecting bytes of operand A, cnt = lane index
// LOAD_B | collecting bytes of operand B, cnt = lane index
// HOLD   | pair complete and stable, waiting for op_ready
module operand_loader #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    operand_loader_if.slave bus
);

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        HOLD   = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;

    logic        xfer;
    logic        byte_ok;
    logic [1:0]  lane;
    logic [4:0]  lane_lsb;

`ifdef LOADER_PARITY_EN
    logic        par_err_q, par_err_d;

    // Odd parity over data plus parity bit marks a good byte.
    assign byte_ok = ^{bus.in_data, bus.in_parity};
`else
    assign byte_ok = 1'b1;
`endif

    assign xfer     = bus.in_valid && (state_q != HOLD);
    assign lane     = LSB_FIRST ? cnt_q : (2'd3 - cnt_q);
    assign lane_lsb = {lane, 3'b000};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;

        case (state_q)
            LOAD_A: begin
                if (xfer) begin
                    if (!byte_ok) begin
                        cnt_d = 2'd0;
                    end else begin
                        a_d[lane_lsb +: 8] = bus.in_data;
                        cnt_d              = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_d = LOAD_B;
                        end
                    end
                end
            end

            LOAD_B: begin
                if (xfer) begin
                    if (!byte_ok) begin
                        // A bad byte abandons the whole pair, not just operand B.
                        state_d = LOAD_A;
                        cnt_d   = 2'd0;
                    end else begin
                        b_d[lane_lsb +: 8] = bus.in_data;
                        cnt_d              = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_d = HOLD;
                        end
                    end
                end
            end

            HOLD: begin
                if (bus.op_ready) begin
                    state_d = LOAD_A;
                    cnt_d   = 2'd0;
                end
            end

            default: begin
                state_d = LOAD_A;
                cnt_d   = 2'd0;
            end
        endcase
    end

`ifdef LOADER_PARITY_EN
    always_comb begin
        par_err_d = xfer && !byte_ok;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD_A;
            cnt_q   <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

`ifdef LOADER_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign bus.par_err = par_err_q;
`endif

    assign bus.in_ready = (state_q != HOLD);
    assign bus.op_valid = (state_q == HOLD);
    assign bus.A        = a_q;
    assign bus.B        = b_q;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader: both byte orders side by side against a pair-level model.
// Define LOADER_PARITY_EN to also exercise the parity path.
module tb_operand_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       op_ready = 1'b0;
    logic [7:0] in_data  = 8'h00;
`ifdef LOADER_PARITY_EN
    logic       in_parity = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    operand_loader_if if0 ();
    operand_loader_if if1 ();

    assign if0.in_data  = in_data;
    assign if0.in_valid = in_valid;
    assign if0.op_ready = op_ready;
    assign if1.in_data  = in_data;
    assign if1.in_valid = in_valid;
    assign if1.op_ready = op_ready;
`ifdef LOADER_PARITY_EN
    assign if0.in_parity = in_parity;
    assign if1.in_parity = in_parity;
`endif

    operand_loader #(.LSB_FIRST(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    operand_loader #(.LSB_FIRST(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    // Pair-level reference: m_n = number of good bytes taken for the current pair (0..8).
    int          m_n    = 0;
    bit          m_hold = 1'b0;
    bit          m_perr = 1'b0;
    logic [31:0] ma0 = 0, mb0 = 0, ma1 = 0, mb1 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] put_byte(input logic [31:0] w, input int sh, input logic [7:0] d);
        return (w & ~(32'hFF << sh)) | ({24'd0, d} << sh);
    endfunction

    task automatic model_step();
        bit par_bad;
        int k;
`ifdef LOADER_PARITY_EN
        par_bad = ((^{in_data, in_parity}) == 1'b0);
`else
        par_bad = 1'b0;
`endif
        if (rst) begin
            m_n = 0; m_hold = 0; m_perr = 0;
            ma0 = 0; mb0 = 0; ma1 = 0; mb1 = 0;
        end else begin
            m_perr = 0;
            if (m_hold) begin
                if (op_ready) begin
                    m_hold = 0;
                    m_n    = 0;
                end
            end else if (in_valid) begin
                if (par_bad) begin
                    m_n    = 0;
                    m_perr = 1;
                end else begin
                    k = m_n % 4;
                    if (m_n < 4) begin
                        ma0 = put_byte(ma0, 8 * k, in_data);
                        ma1 = put_byte(ma1, 24 - 8 * k, in_data);
                    end else begin
                        mb0 = put_byte(mb0, 8 * k, in_data);
                        mb1 = put_byte(mb1, 24 - 8 * k, in_data);
                    end
                    m_n++;
                    if (m_n == 8) m_hold = 1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("in_ready0", {31'd0, if0.in_ready}, {31'd0, ~m_hold});
        chk("op_valid0", {31'd0, if0.op_valid}, {31'd0, m_hold});
        chk("A0", if0.A, ma0);
        chk("B0", if0.B, mb0);
        chk("in_ready1", {31'd0, if1.in_ready}, {31'd0, ~m_hold});
        chk("op_valid1", {31'd0, if1.op_valid}, {31'd0, m_hold});
        chk("A1", if1.A, ma1);
        chk("B1", if1.B, mb1);
`ifdef LOADER_PARITY_EN
        chk("par_err0", {31'd0, if0.par_err}, {31'd0, m_perr});
        chk("par_err1", {31'd0, if1.par_err}, {31'd0, m_perr});
`endif
    endtask

    task automatic drive_byte(input logic [7:0] d, input bit good);
        in_valid = 1'b1;
        in_data  = d;
`ifdef LOADER_PARITY_EN
        in_parity = good ? ~(^d) : (^d);
`else
        if (!good) $display("note: parity build disabled, byte sent as good");
`endif
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int g = 0; g < n; g++) begin
            in_data  = 8'($urandom);
            op_ready = 1'($urandom);
            tick();
        end
        op_ready = 1'b0;
    endtask

    task automatic release_pair();
        in_valid = 1'b0;
        op_ready = 1'b1;
        tick();
        chk("release_op_valid", {31'd0, if0.op_valid}, 32'd0);
        chk("release_in_ready", {31'd0, if0.in_ready}, 32'd1);
        op_ready = 1'b0;
    endtask

    typedef struct {
        logic [63:0] bytes;   // first byte in [63:56]
        int          gap;     // -1: random 1..3 idle cycles between bytes
        bit          mid_rst; // reset after 5 transfers before this vector
        bit          hold5;   // stall 5 cycles with in_valid=1 while holding
        logic [31:0] a0, b0, a1, b1;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [7:0] bt;

        vecs[0] = '{64'h01000000_02000000,  0, 1'b0, 1'b0,
                    32'h00000001, 32'h00000002, 32'h01000000, 32'h02000000};
        vecs[1] = '{64'hFFFFFFFF_01000000,  0, 1'b0, 1'b1,
                    32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h01000000};
        vecs[2] = '{64'h01000000_02000000, -1, 1'b0, 1'b0,
                    32'h00000001, 32'h00000002, 32'h01000000, 32'h02000000};
        vecs[3] = '{64'h10000000_20000000,  0, 1'b1, 1'b0,
                    32'h00000010, 32'h00000020, 32'h10000000, 32'h20000000};
        vecs[4] = '{64'h12345678_9ABCDEF0,  0, 1'b0, 1'b0,
                    32'h78563412, 32'hF0DEBC9A, 32'h12345678, 32'h9ABCDEF0};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_in_ready", {31'd0, if0.in_ready}, 32'd1);
        chk("reset_op_valid", {31'd0, if0.op_valid}, 32'd0);
        chk("reset_A", if0.A, 32'd0);
        chk("reset_B", if1.B, 32'd0);

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].mid_rst) begin
                for (int j = 0; j < 5; j++) begin
                    drive_byte(8'($urandom_range(255, 1)), 1'b1);
                    tick();
                end
                in_valid = 1'b1;
                rst      = 1'b1;
                tick();
                rst      = 1'b0;
                in_valid = 1'b0;
                chk("midrst_A", if0.A, 32'd0);
                chk("midrst_B", if0.B, 32'd0);
                chk("midrst_op_valid", {31'd0, if0.op_valid}, 32'd0);
                chk("midrst_in_ready", {31'd0, if0.in_ready}, 32'd1);
            end
            for (int j = 0; j < 8; j++) begin
                bt = vecs[i].bytes[63 - 8 * j -: 8];
                drive_byte(bt, 1'b1);
                op_ready = 1'($urandom);
                tick();
                op_ready = 1'b0;
                if (j < 7) idle(vecs[i].gap < 0 ? int'($urandom_range(3, 1)) : vecs[i].gap);
            end
            in_valid = 1'b0;
            chk("vec_op_valid", {31'd0, if0.op_valid}, 32'd1);
            chk("vec_in_ready", {31'd0, if0.in_ready}, 32'd0);
            chk("vec_A_lsb", if0.A, vecs[i].a0);
            chk("vec_B_lsb", if0.B, vecs[i].b0);
            chk("vec_A_msb", if1.A, vecs[i].a1);
            chk("vec_B_msb", if1.B, vecs[i].b1);
            if (vecs[i].hold5) begin
                for (int j = 0; j < 5; j++) begin
                    drive_byte(8'($urandom), 1'b1);
                    op_ready = 1'b0;
                    tick();
                end
                in_valid = 1'b0;
                chk("hold_op_valid", {31'd0, if0.op_valid}, 32'd1);
                chk("hold_A", if0.A, vecs[i].a0);
                chk("hold_B", if0.B, vecs[i].b0);
            end
            release_pair();
        end

`ifdef LOADER_PARITY_EN
        for (int j = 0; j < 5; j++) begin
            drive_byte(8'($urandom), 1'b1);
            tick();
        end
        drive_byte(8'h5A, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("parity_err_pulse", {31'd0, if0.par_err}, 32'd1);
        chk("parity_op_valid", {31'd0, if0.op_valid}, 32'd0);
        tick();
        chk("parity_err_clear", {31'd0, if0.par_err}, 32'd0);
        for (int j = 0; j < 8; j++) begin
            drive_byte(vecs[4].bytes[63 - 8 * j -: 8], 1'b1);
            tick();
        end
        in_valid = 1'b0;
        chk("parity_pair_valid", {31'd0, if0.op_valid}, 32'd1);
        chk("parity_pair_A", if0.A, vecs[4].a0);
        chk("parity_pair_B", if1.B, vecs[4].b1);
        release_pair();
`endif

        for (int c = 0; c < 600; c++) begin
            rst      = ($urandom_range(99) == 0);
            in_valid = ($urandom_range(3) != 0);
            in_data  = 8'($urandom);
            op_ready = ($urandom_range(2) == 0);
`ifdef LOADER_PARITY_EN
            in_parity = ($urandom_range(9) == 0) ? (^in_data) : ~(^in_data);
`endif
            tick();
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        op_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 Parameter LSB_FIRST, default 1: byte order of serial operand input (1 = least-significant byte first, 0 = most-significant byte first).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_data  input  8  operand byte stream; A bytes first, then B bytes.
REQ-005 in_valid  input  1  in_data holds a valid byte.
REQ-006 in_ready  output  1  loader can accept a byte this cycle.
REQ-007 A  output  32  assembled operand A, driven to the downstream 32-bit adder's A input.
REQ-008 B  output  32  assembled operand B, driven to the downstream 32-bit adder's B input.
REQ-009 op_valid  output  1  A and B form a complete, stable operand pair.
REQ-010 op_ready  input  1  downstream consumer accepts the pair this cycle.

Function
REQ-011 Byte transfer occurs in a cycle where in_valid=1 and in_ready=1; no other cycle alters A, B or the byte counter.
REQ-012 FSM has exactly three states: LOAD_A, LOAD_B, HOLD; the 2-bit byte counter cnt selects the byte lane.
REQ-013 LOAD_A: transfer writes in_data into A lane cnt; cnt increments mod 4; transfer at cnt=3 moves to LOAD_B with cnt=0.
REQ-014 LOAD_B: same lane rule for B; transfer at cnt=3 moves to HOLD.
REQ-015 Lane mapping: LSB_FIRST=1 -> byte k fills bits [8k+7:8k]; LSB_FIRST=0 -> byte k fills bits [31-8k:24-8k].
REQ-016 in_ready = 1 in LOAD_A and LOAD_B, 0 in HOLD, decoded from registered state only.
REQ-017 op_valid = 1 exactly while in HOLD; it rises the cycle after the 8th byte transfer (latency 1 cycle).
REQ-018 HOLD with op_ready=0: A, B, op_valid remain unchanged indefinitely; in_valid is ignored.
REQ-019 HOLD with op_ready=1: next state LOAD_A, cnt=0, op_valid=0 and in_ready=1 next cycle.
REQ-020 A and B keep their last values until overwritten lane by lane; unwritten lanes retain old data.
REQ-021 op_ready while not in HOLD has no effect.
REQ-022 Idle cycles (in_valid=0) between bytes do not affect the assembled result.
REQ-023 Peak throughput: one operand pair per 9 cycles (8 transfers + 1 HOLD cycle with op_ready=1).

Reset
REQ-024 rst=1 at a rising edge forces state=LOAD_A, cnt=0, A=0, B=0, op_valid=0 on the next cycle, overriding any simultaneous transfer or handshake.
REQ-025 in_ready=1 from the first cycle after reset.
REQ-026 Reset mid-load discards all partial bytes; the next 8 transfers form a fresh pair.

Configuration
REQ-027 Macro LOADER_PARITY_EN, when defined: adds input in_parity (1 bit) and output par_err (1 bit, reset 0).
REQ-028 With LOADER_PARITY_EN: a transfer whose in_data plus in_parity XOR is 0 (even parity) is discarded, state goes to LOAD_A with cnt=0, and par_err pulses 1 for exactly the following cycle; A/B lane contents are not written.
REQ-029 Without LOADER_PARITY_EN: in_parity and par_err do not exist and every transfer is accepted.

Verification
REQ-030 Reset, bytes 01 00 00 00 02 00 00 00 back-to-back -> A=0x00000001, B=0x00000002, op_valid=1 and in_ready=0 the cycle after byte 8.
REQ-031 Bytes FF FF FF FF 01 00 00 00, op_ready=0 for 5 cycles with in_valid=1 -> op_valid held, A=0xFFFFFFFF, B=0x00000001 stable, no byte captured; op_ready=1 -> op_valid=0 and in_ready=1 next cycle.
REQ-032 Same 8 bytes as REQ-030 with 1-3 idle cycles between each -> identical A, B, op_valid rises one cycle after byte 8.
REQ-033 rst=1 after 5 transfers -> A=0, B=0, op_valid=0; following bytes 10 00 00 00 20 00 00 00 -> A=0x10, B=0x20.
REQ-034 LSB_FIRST=0, bytes 12 34 56 78 9A BC DE F0 -> A=0x12345678, B=0x9ABCDEF0.
REQ-035 LOADER_PARITY_EN, bad parity on byte 6 -> par_err=1 one cycle, op_valid stays 0, next 8 good bytes produce a correct pair.
